// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operand width,
// operation encodings, FSM state type and a small op-classification helper.
package muldiv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned RADDR_W = 5;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Divide-class ops share op[1]; op[0] selects the upper accumulator half.
  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle unsigned multiply (shift-add) / divide (restoring) unit
// with register-file writeback. Optional MULDIV_FAST_ZERO_EN skips iteration
// for zero multiply operands and zero divisors.
module mul_div_unit
  import muldiv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [RADDR_W-1:0]   rd_addr,
  output logic                 busy,
  output logic [XLEN-1:0]      result,
  output logic [RADDR_W-1:0]   wb_addr,
  output logic                 wb_en,
  output logic                 done
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [2*XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]      opnd_q, opnd_d;
  logic [RADDR_W-1:0]   rd_q, rd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wb_en_q, wb_en_d;
  logic [XLEN-1:0]      result_q, result_d;
  logic [RADDR_W-1:0]   wb_addr_q, wb_addr_d;

  op_e                  op_in_c;
  logic                 last_iter_c;
  logic                 fast_zero_c;
  logic [XLEN:0]        add_sum_c;
  logic [XLEN+1:0]      sub_diff_c;
  logic [2*XLEN-1:0]    acc_step_c;
  logic                 unused_diff_msb;

  assign op_in_c     = op_e'(op);
  assign last_iter_c = (cnt_q == CNT_W'(ITERS - 1));

`ifdef MULDIV_FAST_ZERO_EN
  logic [XLEN-1:0] fast_res_c;
  assign fast_zero_c = is_div(op_in_c) ? (rs2_data == '0)
                                       : ((rs1_data == '0) || (rs2_data == '0));
  assign fast_res_c  = !is_div(op_in_c) ? '0
                     : (op_in_c[0] ? rs1_data : {XLEN{1'b1}});
`else
  assign fast_zero_c = 1'b0;
`endif

  // One iteration: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide.
  assign add_sum_c       = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign sub_diff_c      = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
  assign unused_diff_msb = sub_diff_c[XLEN];

  always_comb begin
    acc_step_c = acc_q;
    if (is_div(op_q)) begin
      if (sub_diff_c[XLEN+1]) acc_step_c = {acc_q[2*XLEN-2:0], 1'b0};
      else                    acc_step_c = {sub_diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      if (acc_q[0]) acc_step_c = {add_sum_c, acc_q[XLEN-1:1]};
      else          acc_step_c = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = fast_zero_c ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_iter_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    op_d      = op_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    done_d    = 1'b0;
    wb_en_d   = 1'b0;
    busy_d    = (state_d != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = op_in_c;
          acc_d  = {{XLEN{1'b0}}, rs1_data};
          opnd_d = rs2_data;
          rd_d   = rd_addr;
          cnt_d  = '0;
`ifdef MULDIV_FAST_ZERO_EN
          if (fast_zero_c) begin
            result_d  = fast_res_c;
            wb_addr_d = rd_addr;
            done_d    = 1'b1;
            wb_en_d   = (rd_addr != '0);
          end
`endif
        end
      end
      ST_RUN: begin
        acc_d = acc_step_c;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter_c) begin
          result_d  = op_q[0] ? acc_step_c[2*XLEN-1:XLEN] : acc_step_c[XLEN-1:0];
          wb_addr_d = rd_q;
          done_d    = 1'b1;
          wb_en_d   = (rd_q != '0);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      acc_q     <= '0;
      opnd_q    <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      result_q  <= '0;
      wb_addr_q <= '0;
    end else begin
      op_q      <= op_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_en   = wb_en_q;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;

endmodule
